// File: rtl/alu_seq.sv
// Handshaked N-bit ALU with registered result, 4-bit flags and an iterative shift-add multiply.
// One operation in flight at a time: IDLE accepts, BUSY iterates the multiply, DONE holds the result.
module alu_seq #(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   opcode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [3:0]   flags,
  output logic         illegal
);

  localparam int unsigned SW = $clog2(N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_NOR  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_ROTR = 4'd5;
  localparam logic [3:0] OP_POP  = 4'd6;
  localparam logic [3:0] OP_ABS  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_ROTL = 4'd9;

  logic [1:0]     r_state;
  logic [N-1:0]   r_result;
  logic [3:0]     r_flags;
  logic           r_illegal;
  logic [CNT_W-1:0] r_cnt;
  logic [2*N-1:0] r_acc;
  logic [2*N-1:0] r_mcand;
  logic [N-1:0]   r_mplier;

  logic [N:0]     w_sum;
  logic [N-1:0]   w_diff;
  logic [SW-1:0]  w_sh;
  logic [N-1:0]   w_rotr;
  logic [N-1:0]   w_rotl;
  logic [N-1:0]   w_pop;
  logic [N-1:0]   w_res;
  logic           w_carry;
  logic           w_ovf;
  logic           w_ill;
  logic [2*N-1:0] w_acc_nxt;
  logic [N-1:0]   w_mul_lo;
  logic [N-1:0]   w_mul_hi;
  logic           w_mul_last;

  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = a - b;
  assign w_sh   = b[SW-1:0];

  // Rotation indices wrap naturally in SW bits because N is a power of two.
  always_comb begin
    w_rotr = '0;
    w_rotl = '0;
    w_pop  = '0;
    for (int i = 0; i < N; i++) begin
      w_rotr[i] = a[SW'(i) + w_sh];
      w_rotl[i] = a[SW'(i) - w_sh];
      w_pop     = w_pop + N'(a[i]) + N'(b[i]);
    end
  end

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_ill   = 1'b0;
    case (opcode)
      OP_ADD: begin
        w_res   = w_sum[N-1:0];
        w_carry = w_sum[N];
        w_ovf   = (a[N-1] == b[N-1]) && (w_sum[N-1] != a[N-1]);
      end
      OP_SUB: begin
        w_res   = w_diff;
        w_carry = (a < b);
        w_ovf   = (a[N-1] != b[N-1]) && (w_diff[N-1] != a[N-1]);
      end
      OP_AND:  w_res = a & b;
      OP_NOR:  w_res = ~(a | b);
      OP_XOR:  w_res = a ^ b;
      OP_ROTR: w_res = w_rotr;
      OP_ROTL: w_res = w_rotl;
      OP_POP:  w_res = w_pop;
      OP_ABS: begin
        w_res = b[N-1] ? (~b + 1'b1) : b;
        w_ovf = (b == {1'b1, {(N-1){1'b0}}});
      end
      OP_MUL:  w_res = '0;
      default: w_ill = 1'b1;
    endcase
  end

  assign w_acc_nxt  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mul_lo   = w_acc_nxt[N-1:0];
  assign w_mul_hi   = w_acc_nxt[2*N-1:N];
  assign w_mul_last = (r_cnt == CNT_W'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_result  <= '0;
      r_flags   <= '0;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (opcode == OP_MUL) begin
              r_state  <= S_BUSY;
              r_acc    <= '0;
              r_mcand  <= {{N{1'b0}}, a};
              r_mplier <= b;
              r_cnt    <= '0;
            end else begin
              r_state   <= S_DONE;
              r_result  <= w_res;
              r_flags   <= {w_carry, w_ovf, w_res[N-1], (w_res == '0)};
              r_illegal <= w_ill;
            end
          end
        end
        S_BUSY: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          // Final partial product is folded in combinationally on the last iteration.
          if (w_mul_last) begin
            r_state   <= S_DONE;
            r_result  <= w_mul_lo;
            r_flags   <= {(w_mul_hi != '0), 1'b0, w_mul_lo[N-1], (w_mul_lo == '0)};
            r_illegal <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign flags     = r_flags;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes expected responses, a monitor pops on each handshake.
module tb_alu_seq;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   opcode;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic [3:0]   flags;
  logic         illegal;

  typedef struct packed {
    logic [7:0] res;
    logic [3:0] flg;
    logic       ill;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic rand_rdy = 1'b0;
  exp_t mon_e;
  exp_t mon_got;

  alu_seq #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opcode   (opcode),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flags    (flags),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [7:0] r, input logic [3:0] f, input logic il);
    exp_t e;
    e.res = r;
    e.flg = f;
    e.ill = il;
    return e;
  endfunction

  // Reference model straight from the opcode table, using plain integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
    int   ux, uy, sx, sy, r, k;
    logic c, v, il;
    logic [7:0] rr;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    c = 1'b0;
    v = 1'b0;
    il = 1'b0;
    r = 0;
    case (op)
      4'd0: begin r = ux + uy; c = (r > 255); v = (sx + sy > 127) || (sx + sy < -128); end
      4'd1: begin r = ux - uy; c = (ux < uy); v = (sx - sy > 127) || (sx - sy < -128); end
      4'd2: r = ux & uy;
      4'd3: r = ~(ux | uy);
      4'd4: r = ux ^ uy;
      4'd5: begin k = uy % 8; r = (ux >> k) | (ux << (8 - k)); end
      4'd9: begin k = uy % 8; r = (ux << k) | (ux >> (8 - k)); end
      4'd6: r = $countones(x) + $countones(y);
      4'd7: begin r = (sy < 0) ? -sy : sy; v = (sy == -128); end
      4'd8: begin r = ux * uy; c = (r > 255); end
      default: begin r = 0; il = 1'b1; end
    endcase
    rr = r[7:0];
    return mk(rr, {c, v, rr[7], (rr == 8'h00)}, il);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      mon_got = {result, flags, illegal};
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got res=%h flg=%b ill=%b required none",
                 result, flags, illegal);
      end else begin
        mon_e = q.pop_front();
        if (mon_got !== mon_e) begin
          n_err++;
          $display("FAIL scoreboard: got res=%h flg=%b ill=%b required res=%h flg=%b ill=%b",
                   mon_got.res, mon_got.flg, mon_got.ill, mon_e.res, mon_e.flg, mon_e.ill);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                      input exp_t e);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("send_timeout", 32'(in_ready), 32'd1);
    end else begin
      in_valid = 1'b1;
      opcode   = op;
      a        = x;
      b        = y;
      @(posedge clk);
      q.push_back(e);
      #1;
      in_valid = 1'b0;
      opcode   = 4'($urandom);
      a        = 8'($urandom);
      b        = 8'($urandom);
    end
  endtask

  task automatic wait_out(output int lat, output int busy);
    lat  = 0;
    busy = 0;
    while (!out_valid && lat < 50) begin
      if (!in_ready) busy++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, busy, t;
    logic [3:0] op;
    logic [7:0] x, y;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    opcode    = 4'd0;
    a         = 8'd0;
    b         = 8'd0;

    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;

    send(4'd0, 8'hFF, 8'h01, mk(8'h00, 4'b1001, 1'b0));
    wait_out(lat, busy);
    check("add_latency", 32'(lat), 32'd0);
    send(4'd1, 8'h80, 8'h01, mk(8'h7F, 4'b0100, 1'b0));
    send(4'd1, 8'h03, 8'h05, mk(8'hFE, 4'b1010, 1'b0));
    send(4'd8, 8'h10, 8'h11, mk(8'h10, 4'b1000, 1'b0));
    wait_out(lat, busy);
    check("mul_latency", 32'(lat), 32'd8);
    check("mul_busy_cycles", 32'(busy), 32'd8);
    send(4'd7, 8'h00, 8'h80, mk(8'h80, 4'b0110, 1'b0));
    send(4'd5, 8'h81, 8'h09, mk(8'hC0, 4'b0010, 1'b0));
    send(4'd9, 8'h81, 8'h01, mk(8'h03, 4'b0000, 1'b0));
    send(4'd5, 8'h5A, 8'h08, mk(8'h5A, 4'b0000, 1'b0));
    send(4'd6, 8'hFF, 8'hFF, mk(8'h10, 4'b0000, 1'b0));

    // Stall: result must hold and new requests must be ignored while out_ready is low.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(4'd0, 8'h7F, 8'h01, mk(8'h80, 4'b0110, 1'b0));
    wait_out(lat, busy);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_result", 32'(result), 32'h80);
      check("stall_flags", 32'(flags), 32'b0110);
      in_valid = 1'b1;
      opcode   = 4'd4;
      a        = 8'($urandom);
      b        = 8'($urandom);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reset in the middle of a multiply abandons it.
    send(4'd8, 8'h10, 8'h22, mk(8'h20, 4'b1000, 1'b0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    void'(q.pop_back());
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_result", 32'(result), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(4'd8, 8'h03, 8'h05, mk(8'h0F, 4'b0000, 1'b0));
    wait_out(lat, busy);
    check("mul2_latency", 32'(lat), 32'd8);
    send(4'd12, 8'h33, 8'h44, mk(8'h00, 4'b0001, 1'b1));

    rand_rdy = 1'b1;
    repeat (250) begin
      op = 4'($urandom_range(0, 15));
      x  = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
      y  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(op, x, y, model(op, x, y));
    end

    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_queue", 32'(q.size()), 32'd0);
    rand_rdy = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
